// File: rtl/sdram_req_arb_pkg.sv
// Shared SDRAM parameters: default address/length widths and the
// request-arbiter FSM encoding used by the SDRAM controller slice.
package sdram_req_arb_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_LEN_W  = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_BUSY = 3'd2,
    RD_REQ  = 3'd3,
    RD_BUSY = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_addr_gen.sv
// Burst start-address generator: holds one address, wraps inside
// [min_addr, max_addr) and defers load pulses that arrive mid-burst.
// Ports: clk, rst_n, init_rise, load, busy, done, burst,
//        min_addr, max_addr -> addr.
module sdram_addr_gen
  import sdram_req_arb_pkg::*;
#(
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int LEN_W  = SDRAM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_rise,
  input  logic              load,
  input  logic              busy,
  input  logic              done,
  input  logic [LEN_W-1:0]  burst,
  input  logic [ADDR_W-1:0] min_addr,
  input  logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W-1:0] addr
);

  logic              pend;
  logic [ADDR_W:0]   nxt;
  logic              wrap;

  // One spare bit so addr + burst can never overflow.
  assign nxt  = {1'b0, addr}
              + {{(ADDR_W+1-LEN_W){1'b0}}, burst};
  assign wrap = nxt >= {1'b0, max_addr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      pend <= 1'b0;
    end else if (init_rise) begin
      addr <= min_addr;
      pend <= 1'b0;
    end else if (done) begin
      // A load seen during the burst wins over the advance.
      if (pend || load || wrap)
        addr <= min_addr;
      else
        addr <= nxt[ADDR_W-1:0];
      pend <= 1'b0;
    end else if (load) begin
      if (busy)
        pend <= 1'b1;
      else
        addr <= min_addr;
    end
  end

endmodule

// File: rtl/sdram_req_arb.sv
// Round-robin write/read request arbiter in front of the SDRAM
// state controller; issues one registered burst request at a time.
// Ports: clk, rst_n, sdram_init_done, FIFO levels (wr/rd_usedw),
//        regions (wr/rd_min/max_addr), lengths (wr/rd_len),
//        wr/rd_load, read_valid, sdram_wr/rd_ack ->
//        sdram_wr/rd_req, sdram_wr/rd_addr, sdram_wr/rd_burst.
module sdram_req_arb
  import sdram_req_arb_pkg::*;
#(
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int LEN_W  = SDRAM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [LEN_W-1:0]  wr_usedw,
  input  logic [LEN_W-1:0]  rd_usedw,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              read_valid,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [LEN_W-1:0]  sdram_wr_burst,
  output logic [LEN_W-1:0]  sdram_rd_burst
);

  arb_state_e state, state_nxt;
  logic       last_wr;
  logic       init_d;
  logic       init_rise;
  logic       wr_ok, rd_ok;
  logic       grant_wr, grant_rd;
  logic       wr_done, rd_done;

  assign init_rise = sdram_init_done & ~init_d;
  assign wr_ok = sdram_init_done
              && (wr_usedw >= wr_len);
  assign rd_ok = sdram_init_done && read_valid
              && (rd_usedw < rd_len);

  // Ack falling inside BUSY marks the end of the burst.
  assign wr_done = (state == WR_BUSY) && !sdram_wr_ack;
  assign rd_done = (state == RD_BUSY) && !sdram_rd_ack;

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the side not granted last goes first.
        if (wr_ok && (!rd_ok || !last_wr)) begin
          state_nxt = WR_REQ;
          grant_wr  = 1'b1;
        end else if (rd_ok) begin
          state_nxt = RD_REQ;
          grant_rd  = 1'b1;
        end
      end
      WR_REQ:  if (sdram_wr_ack)  state_nxt = WR_BUSY;
      WR_BUSY: if (!sdram_wr_ack) state_nxt = IDLE;
      RD_REQ:  if (sdram_rd_ack)  state_nxt = RD_BUSY;
      RD_BUSY: if (!sdram_rd_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sdram_wr_req   <= 1'b0;
      sdram_rd_req   <= 1'b0;
      sdram_wr_burst <= '0;
      sdram_rd_burst <= '0;
      last_wr        <= 1'b0;
      init_d         <= 1'b0;
    end else begin
      state        <= state_nxt;
      init_d       <= sdram_init_done;
      sdram_wr_req <= (state_nxt == WR_REQ);
      sdram_rd_req <= (state_nxt == RD_REQ);
      if (grant_wr) begin
        sdram_wr_burst <= wr_len;
        last_wr        <= 1'b1;
      end
      if (grant_rd) begin
        sdram_rd_burst <= rd_len;
        last_wr        <= 1'b0;
      end
    end
  end

  sdram_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_wr_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_rise (init_rise),
    .load      (wr_load),
    .busy      (state == WR_BUSY),
    .done      (wr_done),
    .burst     (sdram_wr_burst),
    .min_addr  (wr_min_addr),
    .max_addr  (wr_max_addr),
    .addr      (sdram_wr_addr)
  );

  sdram_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_rd_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_rise (init_rise),
    .load      (rd_load),
    .busy      (state == RD_BUSY),
    .done      (rd_done),
    .burst     (sdram_rd_burst),
    .min_addr  (rd_min_addr),
    .max_addr  (rd_max_addr),
    .addr      (sdram_rd_addr)
  );

endmodule

// File: tb/tb_sdram_req_arb.sv
// Self-checking bench for sdram_req_arb: controller model plus a
// scoreboard of expected grants (side, address, burst).
module tb_sdram_req_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdram_init_done;
  logic [9:0]  wr_usedw, rd_usedw;
  logic [23:0] wr_min_addr, wr_max_addr;
  logic [23:0] rd_min_addr, rd_max_addr;
  logic [9:0]  wr_len, rd_len;
  logic        wr_load, rd_load, read_valid;
  logic        sdram_wr_ack, sdram_rd_ack;
  logic        sdram_wr_req, sdram_rd_req;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic [9:0]  sdram_wr_burst, sdram_rd_burst;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [9:0]  burst;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          total = 0;
  logic [23:0] m_wr, m_rd;
  bit          m_last_wr;

  always #5 clk = ~clk;

  sdram_req_arb dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .wr_usedw        (wr_usedw),
    .rd_usedw        (rd_usedw),
    .wr_min_addr     (wr_min_addr),
    .wr_max_addr     (wr_max_addr),
    .rd_min_addr     (rd_min_addr),
    .rd_max_addr     (rd_max_addr),
    .wr_len          (wr_len),
    .rd_len          (rd_len),
    .wr_load         (wr_load),
    .rd_load         (rd_load),
    .read_valid      (read_valid),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_wr_addr   (sdram_wr_addr),
    .sdram_rd_addr   (sdram_rd_addr),
    .sdram_wr_burst  (sdram_wr_burst),
    .sdram_rd_burst  (sdram_rd_burst)
  );

  function automatic logic [23:0] adv(
    input logic [23:0] a, input logic [9:0] l,
    input logic [23:0] mn, input logic [23:0] mx);
    logic [24:0] n;
    n = {1'b0, a} + {15'd0, l};
    return (n >= {1'b0, mx}) ? mn : n[23:0];
  endfunction

  task automatic push_wr();
    sb.push_back('{1'b1, m_wr, wr_len});
    m_wr = adv(m_wr, wr_len, wr_min_addr, wr_max_addr);
    m_last_wr = 1'b1;
  endtask

  task automatic push_rd();
    sb.push_back('{1'b0, m_rd, rd_len});
    m_rd = adv(m_rd, rd_len, rd_min_addr, rd_max_addr);
    m_last_wr = 1'b0;
  endtask

  // Controller model: wait for a request, check it against the
  // scoreboard, then hold ack for ack_n cycles and drop it.
  // act 1: wr_load pulse in BUSY; act 2: drop read_valid at request.
  task automatic serve(input int ack_n, input int act);
    bit   seen;
    bit   is_wr;
    exp_t e;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      total++;
      if (sdram_wr_req && sdram_rd_req)
        $display("FAIL overlap: wr_req=1 rd_req=1 want one-hot");
      else
        pass_cnt++;
      if (sdram_wr_req || sdram_rd_req) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      $display("FAIL req_timeout: no request in 60 cycles");
      return;
    end
    if (sb.size() == 0) begin
      $display("FAIL sb_empty: unexpected request wr=%0b",
               sdram_wr_req);
      return;
    end
    pass_cnt++;
    e = sb.pop_front();
    is_wr = sdram_wr_req;
    total++;
    if (is_wr !== e.wr)
      $display("FAIL grant_side: got wr=%0b want wr=%0b",
               is_wr, e.wr);
    else
      pass_cnt++;
    total++;
    if ((is_wr ? sdram_wr_addr : sdram_rd_addr) !== e.addr)
      $display("FAIL req_addr: got %0h want %0h",
               is_wr ? sdram_wr_addr : sdram_rd_addr, e.addr);
    else
      pass_cnt++;
    total++;
    if ((is_wr ? sdram_wr_burst : sdram_rd_burst) !== e.burst)
      $display("FAIL req_burst: got %0d want %0d",
               is_wr ? sdram_wr_burst : sdram_rd_burst, e.burst);
    else
      pass_cnt++;
    if (is_wr) sdram_wr_ack = 1'b1;
    else       sdram_rd_ack = 1'b1;
    if (act == 2) read_valid = 1'b0;
    for (int c = 1; c <= ack_n; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if ((sdram_wr_req | sdram_rd_req) !== 1'b0)
          $display("FAIL req_drop: got wr=%0b rd=%0b want 0",
                   sdram_wr_req, sdram_rd_req);
        else
          pass_cnt++;
      end
      if (act == 1 && c == 2) wr_load = 1'b1;
      if (act == 1 && c == 3) wr_load = 1'b0;
    end
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    total++;
    if ({sdram_wr_req, sdram_rd_req} !== 2'b00)
      $display("FAIL %s_req: got %b want 00", tag,
               {sdram_wr_req, sdram_rd_req});
    else
      pass_cnt++;
    total++;
    if ({sdram_wr_addr, sdram_rd_addr} !== 48'd0)
      $display("FAIL %s_addr: got %0h/%0h want 0/0", tag,
               sdram_wr_addr, sdram_rd_addr);
    else
      pass_cnt++;
    total++;
    if ({sdram_wr_burst, sdram_rd_burst} !== 20'd0)
      $display("FAIL %s_burst: got %0d/%0d want 0/0", tag,
               sdram_wr_burst, sdram_rd_burst);
    else
      pass_cnt++;
  endtask

  task automatic pulse_wr_load();
    @(negedge clk);
    wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    m_wr = wr_min_addr;
  endtask

  task automatic test_reset();
    bit any_req;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    wr_usedw = 10'd300;
    any_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (sdram_wr_req || sdram_rd_req) any_req = 1'b1;
    end
    total++;
    if (any_req !== 1'b0)
      $display("FAIL no_init_req: got req want none");
    else
      pass_cnt++;
    check_outputs_zero("pre_init");
  endtask

  task automatic test_single_write();
    m_wr = wr_min_addr;
    m_rd = rd_min_addr;
    m_last_wr = 1'b0;
    push_wr();
    sdram_init_done = 1'b1;
    serve(258, 0);
    wr_usedw = 10'd0;
    total++;
    if (sdram_wr_addr !== 24'd256)
      $display("FAIL single_addr: got %0h want 100", sdram_wr_addr);
    else
      pass_cnt++;
    total++;
    if (sdram_wr_req !== 1'b0)
      $display("FAIL single_idle: got wr_req=%0b want 0",
               sdram_wr_req);
    else
      pass_cnt++;
    total++;
    if (sdram_rd_addr !== rd_min_addr)
      $display("FAIL init_rd_addr: got %0h want %0h",
               sdram_rd_addr, rd_min_addr);
    else
      pass_cnt++;
  endtask

  task automatic test_wrap();
    pulse_wr_load();
    for (int i = 0; i < 5; i++) push_wr();
    wr_usedw = 10'd300;
    for (int i = 0; i < 5; i++) serve(4, 0);
    wr_usedw = 10'd0;
    total++;
    if (sdram_wr_addr !== m_wr)
      $display("FAIL wrap_addr: got %0h want %0h",
               sdram_wr_addr, m_wr);
    else
      pass_cnt++;
  endtask

  task automatic test_round_robin();
    pulse_wr_load();
    for (int i = 0; i < 4; i++) begin
      if (m_last_wr) push_rd();
      else           push_wr();
    end
    wr_usedw   = 10'd512;
    rd_usedw   = 10'd0;
    read_valid = 1'b1;
    for (int i = 0; i < 4; i++) serve(4, 0);
    wr_usedw   = 10'd0;
    read_valid = 1'b0;
    total++;
    if (sdram_rd_addr !== m_rd)
      $display("FAIL rr_rd_addr: got %0h want %0h",
               sdram_rd_addr, m_rd);
    else
      pass_cnt++;
  endtask

  task automatic test_load_pending();
    pulse_wr_load();
    push_wr();
    push_wr();
    push_wr();
    m_wr = wr_min_addr;
    wr_usedw = 10'd300;
    serve(4, 0);
    serve(4, 0);
    serve(6, 1);
    wr_usedw = 10'd0;
    total++;
    if (sdram_wr_addr !== 24'd0)
      $display("FAIL load_pend_addr: got %0h want 0",
               sdram_wr_addr);
    else
      pass_cnt++;
  endtask

  task automatic test_read_valid_drop();
    bit again;
    push_rd();
    rd_usedw   = 10'd0;
    read_valid = 1'b1;
    serve(5, 2);
    total++;
    if (sdram_rd_addr !== m_rd)
      $display("FAIL rv_drop_addr: got %0h want %0h",
               sdram_rd_addr, m_rd);
    else
      pass_cnt++;
    again = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (sdram_rd_req) again = 1'b1;
    end
    total++;
    if (again !== 1'b0)
      $display("FAIL rv_drop_again: got rd_req want none");
    else
      pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    wr_usedw = 10'd300;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sdram_wr_req) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen)
      $display("FAIL rst_mid_req: got no wr_req want one");
    else
      pass_cnt++;
    sdram_wr_ack = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sdram_wr_ack = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_mid");
    wr_min_addr = 24'd64;
    m_wr = 24'd64;
    m_last_wr = 1'b0;
    push_wr();
    @(negedge clk);
    rst_n = 1'b1;
    serve(4, 0);
    wr_usedw = 10'd0;
    total++;
    if (sdram_wr_addr !== 24'd320)
      $display("FAIL rst_mid_adv: got %0h want 140",
               sdram_wr_addr);
    else
      pass_cnt++;
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_left: got %0d entries want 0", sb.size());
    else
      pass_cnt++;
  endtask

  initial begin
    rst_n           = 1'b0;
    sdram_init_done = 1'b0;
    wr_usedw        = 10'd0;
    rd_usedw        = 10'd0;
    wr_min_addr     = 24'd0;
    wr_max_addr     = 24'd1024;
    rd_min_addr     = 24'd2048;
    rd_max_addr     = 24'd3072;
    wr_len          = 10'd256;
    rd_len          = 10'd256;
    wr_load         = 1'b0;
    rd_load         = 1'b0;
    read_valid      = 1'b0;
    sdram_wr_ack    = 1'b0;
    sdram_rd_ack    = 1'b0;
    test_reset();
    test_single_write();
    test_wrap();
    test_round_robin();
    test_load_pending();
    test_read_valid_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", pass_cnt, total + 1);
    $fatal(1);
  end

endmodule
